// File: rtl/ppu_pkg.sv
// Types and address map shared by the PPU and its VRAM/OAM responder.
package ppu_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } PPU_STATES_t;

    typedef enum logic [1:0] {
        SrcFf,
        SrcVram,
        SrcOam
    } rd_src_t;

    typedef enum logic {
        DmaIdle,
        DmaRun
    } dma_state_t;

    localparam logic [15:0] VRAM_BASE    = 16'h8000;
    localparam logic [15:0] VRAM_END     = 16'h9FFF;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] OAM_END      = 16'hFE9F;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam int unsigned VRAM_SIZE    = 8192;
    localparam int unsigned OAM_SIZE     = 160;

    function automatic logic in_vram(input logic [15:0] a);
        return (a >= VRAM_BASE) && (a <= VRAM_END);
    endfunction

    function automatic logic in_oam(input logic [15:0] a);
        return (a >= OAM_BASE) && (a <= OAM_END);
    endfunction

    function automatic logic [7:0] sel_byte(input rd_src_t src, input logic [7:0] vram_q,
                                            input logic [7:0] oam_q);
        case (src)
            SrcVram: return vram_q;
            SrcOam:  return oam_q;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: one source read every DMA_CYCLES_PER_BYTE clocks, written to OAM a cycle later.
module oam_dma_engine
    import ppu_pkg::*;
#(
    parameter int unsigned DMA_CYCLES_PER_BYTE = 4,
    parameter int unsigned DMA_LEN             = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [7:0]  i_src_hi,
    input  logic [7:0]  i_dma_data,
    output logic        o_dma_rd,
    output logic [15:0] o_dma_addr,
    output logic        o_active,
    output logic        o_oam_we,
    output logic [7:0]  o_oam_waddr,
    output logic [7:0]  o_oam_wdata
);

    localparam int unsigned PH_W = $clog2(DMA_CYCLES_PER_BYTE);

    dma_state_t        r_state, w_state_nxt;
    logic [15:0]       r_src, w_src_nxt;
    logic [7:0]        r_idx, w_idx_nxt;
    logic [PH_W-1:0]   r_ph, w_ph_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DmaIdle;
            r_src   <= 16'h0000;
            r_idx   <= 8'h00;
            r_ph    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_idx   <= w_idx_nxt;
            r_ph    <= w_ph_nxt;
        end
    end

    // A start request always wins, so an FF46 write mid-transfer restarts from byte 0.
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_idx_nxt   = r_idx;
        w_ph_nxt    = r_ph;
        if (i_start) begin
            w_state_nxt = DmaRun;
            w_src_nxt   = {i_src_hi, 8'h00};
            w_idx_nxt   = 8'h00;
            w_ph_nxt    = '0;
        end else if (r_state == DmaRun) begin
            if (r_ph == PH_W'(DMA_CYCLES_PER_BYTE - 1)) begin
                w_ph_nxt = '0;
                if (r_idx == 8'(DMA_LEN - 1)) begin
                    w_state_nxt = DmaIdle;
                end else begin
                    w_idx_nxt = r_idx + 8'd1;
                end
            end else begin
                w_ph_nxt = r_ph + PH_W'(1);
            end
        end
    end

    assign o_active    = (r_state == DmaRun);
    assign o_dma_rd    = o_active && (r_ph == '0);
    assign o_dma_addr  = r_src + {8'h00, r_idx};
    assign o_oam_we    = o_active && (r_ph == PH_W'(1));
    assign o_oam_waddr = r_idx;
    assign o_oam_wdata = i_dma_data;

endmodule

// File: rtl/vram_oam_responder.sv
// VRAM/OAM owner: 1-cycle PPU reads, mode-locked CPU access and the FF46 OAM DMA engine.
module vram_oam_responder
    import ppu_pkg::*;
#(
    parameter int unsigned DMA_CYCLES_PER_BYTE = 4,
    parameter int unsigned DMA_LEN             = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ADDR,
    input  logic        WR,
    input  logic        RD,
    input  logic [7:0]  MMIO_DATA_out,
    output logic [7:0]  MMIO_DATA_in,
    input  logic [1:0]  PPU_MODE,
    input  logic        LCD_EN,
    input  logic        PPU_RD,
    input  logic [15:0] PPU_ADDR,
    output logic [7:0]  PPU_DATA_out,
    output logic        DMA_RD,
    output logic [15:0] DMA_ADDR,
    input  logic [7:0]  DMA_DATA_in,
    output logic        DMA_ACTIVE
);

    logic [7:0] r_vram [0:VRAM_SIZE-1];
    logic [7:0] r_oam  [0:OAM_SIZE-1];

    logic [7:0] r_vram_ppu, r_vram_cpu, r_oam_ppu, r_oam_cpu;
    rd_src_t    r_ppu_src, r_cpu_src;

    PPU_STATES_t w_mode;
    logic        w_vram_lock, w_oam_lock;
    logic        w_cpu_vram, w_cpu_oam, w_ppu_vram, w_ppu_oam;
    logic        w_dma_start, w_dma_we;
    logic [7:0]  w_dma_waddr, w_dma_wdata;
    logic        w_oam_we;
    logic [7:0]  w_oam_waddr, w_oam_wdata;

    assign w_mode      = PPU_STATES_t'(PPU_MODE);
    assign w_cpu_vram  = in_vram(ADDR);
    assign w_cpu_oam   = in_oam(ADDR);
    assign w_ppu_vram  = in_vram(PPU_ADDR);
    assign w_ppu_oam   = in_oam(PPU_ADDR);
    assign w_dma_start = WR && (ADDR == DMA_REG_ADDR);
    // Uses the current DMA_ACTIVE, so an access sharing a cycle with an FF46 write sees pre-DMA lock.
    assign w_vram_lock = LCD_EN && (w_mode == DRAW);
    assign w_oam_lock  = DMA_ACTIVE || (LCD_EN && ((w_mode == SCAN) || (w_mode == DRAW)));

    oam_dma_engine #(
        .DMA_CYCLES_PER_BYTE (DMA_CYCLES_PER_BYTE),
        .DMA_LEN             (DMA_LEN)
    ) u_dma (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_dma_start),
        .i_src_hi    (MMIO_DATA_out),
        .i_dma_data  (DMA_DATA_in),
        .o_dma_rd    (DMA_RD),
        .o_dma_addr  (DMA_ADDR),
        .o_active    (DMA_ACTIVE),
        .o_oam_we    (w_dma_we),
        .o_oam_waddr (w_dma_waddr),
        .o_oam_wdata (w_dma_wdata)
    );

    always_comb begin
        w_oam_we    = w_dma_we || (WR && w_cpu_oam && !w_oam_lock);
        w_oam_waddr = ADDR[7:0];
        w_oam_wdata = MMIO_DATA_out;
        if (w_dma_we) begin
            w_oam_waddr = w_dma_waddr;
            w_oam_wdata = w_dma_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (WR && w_cpu_vram && !w_vram_lock) begin
            r_vram[ADDR[12:0]] <= MMIO_DATA_out;
        end
        if (RD && w_cpu_vram) begin
            r_vram_cpu <= r_vram[ADDR[12:0]];
        end
        if (PPU_RD && w_ppu_vram) begin
            r_vram_ppu <= r_vram[PPU_ADDR[12:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (w_oam_we) begin
            r_oam[w_oam_waddr] <= w_oam_wdata;
        end
        if (RD && w_cpu_oam) begin
            r_oam_cpu <= r_oam[ADDR[7:0]];
        end
        if (PPU_RD && w_ppu_oam) begin
            r_oam_ppu <= r_oam[PPU_ADDR[7:0]];
        end
    end

    // Raw RAM read registers carry no reset; the source selects make outputs read FF after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ppu_src <= SrcFf;
            r_cpu_src <= SrcFf;
        end else begin
            if (PPU_RD) begin
                if (w_ppu_vram) begin
                    r_ppu_src <= SrcVram;
                end else if (w_ppu_oam && !DMA_ACTIVE) begin
                    r_ppu_src <= SrcOam;
                end else begin
                    r_ppu_src <= SrcFf;
                end
            end
            if (RD) begin
                if (w_cpu_vram && !w_vram_lock) begin
                    r_cpu_src <= SrcVram;
                end else if (w_cpu_oam && !w_oam_lock) begin
                    r_cpu_src <= SrcOam;
                end else begin
                    r_cpu_src <= SrcFf;
                end
            end
        end
    end

    assign PPU_DATA_out = sel_byte(r_ppu_src, r_vram_ppu, r_oam_ppu);
    assign MMIO_DATA_in = sel_byte(r_cpu_src, r_vram_cpu, r_oam_cpu);

endmodule
